// File: rtl/cpu_pkg.sv
// Shared core-wide types and constants for the 32-bit RISC datapath.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t RESET_PC = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/program_counter.sv
// Architectural PC register: captures the externally computed next PC each cycle,
// optionally clearing low bits so fetch addresses stay aligned.
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned             WIDTH        = XLEN,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = WIDTH'(RESET_PC),
  parameter int unsigned             ALIGN_BITS   = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Pc_in,
  output logic [WIDTH-1:0] Pc_out,
  output logic             Pc_valid
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;

  if (ALIGN_BITS >= WIDTH) begin : g_bad_align_bits
    $error("program_counter: ALIGN_BITS must be smaller than WIDTH");
  end

  if ((RESET_VECTOR & ~ALIGN_MASK) != '0) begin : g_bad_reset_vector
    $error("program_counter: RESET_VECTOR is not aligned to ALIGN_BITS");
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Pc_out   <= RESET_VECTOR;
      Pc_valid <= 1'b0;
    end else begin
      Pc_out   <= Pc_in & ALIGN_MASK;
      Pc_valid <= 1'b1;
    end
  end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: unaligned and word-aligned instances
// share stimulus; a monitor samples between and just after clock edges.
module tb_program_counter;
  import cpu_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  pc_t  Pc_in;
  pc_t  pc_out0, pc_out2;
  logic valid0, valid2;

  always #5 Clk = ~Clk;

  program_counter #(
    .WIDTH(XLEN), .RESET_VECTOR(RESET_PC), .ALIGN_BITS(0)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Pc_in(Pc_in), .Pc_out(pc_out0), .Pc_valid(valid0)
  );

  program_counter #(
    .WIDTH(XLEN), .RESET_VECTOR(RESET_PC), .ALIGN_BITS(2)
  ) dut_a (
    .Clk(Clk), .Rst(Rst), .Pc_in(Pc_in), .Pc_out(pc_out2), .Pc_valid(valid2)
  );

  typedef struct {
    string tag;
    pc_t   pc0;
    pc_t   pc2;
    logic  valid;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;
  bit   done    = 1'b0;

  // Reference state: what each PC register should architecturally hold right now.
  pc_t  m_pc0, m_pc2;
  logic m_valid;

  function automatic pc_t align_down(pc_t v, int unsigned bits);
    pc_t gran;
    gran = pc_t'(1) << bits;
    return v - (v % gran);
  endfunction

  function automatic void model_reset();
    m_pc0   = RESET_PC;
    m_pc2   = RESET_PC;
    m_valid = 1'b0;
  endfunction

  function automatic void push(string tag);
    exp_t e;
    e.tag   = tag;
    e.pc0   = m_pc0;
    e.pc2   = m_pc2;
    e.valid = m_valid;
    sb.push_back(e);
  endfunction

  function automatic void check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Called at a negedge: drives inputs, predicts the mid-cycle and post-posedge
  // views, and optionally drops reset between the posedge and the next negedge.
  task automatic step(input logic rst, input pc_t pc, input bit x_in,
                      input bit async_mid, input string tag);
    Rst   = rst;
    Pc_in = x_in ? 'x : pc;
    if (!rst) model_reset();
    push({tag, "/mid"});
    if (rst) begin
      m_pc0   = align_down(pc, 0);
      m_pc2   = align_down(pc, 2);
      m_valid = 1'b1;
    end else begin
      model_reset();
    end
    push({tag, "/edge"});
    @(posedge Clk);
    if (async_mid) begin
      #2;
      model_reset();
      push({tag, "/async"});
      Rst = 1'b0;
    end
    @(negedge Clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge Clk or negedge Clk or negedge Rst);
      #1;
      if (done) break;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got queue size 0 expected >0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check({e.tag, " pc_out"},    pc_out0, e.pc0);
        check({e.tag, " pc_out_a"},  pc_out2, e.pc2);
        check({e.tag, " valid"},     {31'b0, valid0}, {31'b0, e.valid});
        check({e.tag, " valid_a"},   {31'b0, valid2}, {31'b0, e.valid});
      end
    end
  end

  // Stimulus
  initial begin
    logic rnd_rst;
    bit   rnd_async;
    Rst   = 1'b0;
    Pc_in = 'x;
    model_reset();
    @(posedge Clk);
    #1 started = 1'b1;
    @(negedge Clk);

    step(1'b0, '0,            1'b1, 1'b0, "reset_hold_x");
    step(1'b0, '0,            1'b1, 1'b0, "reset_hold_x");
    step(1'b0, 32'h1234,      1'b0, 1'b0, "reset_hold_1234");

    step(1'b1, 32'h0,         1'b0, 1'b0, "load_0");
    step(1'b1, 32'h1,         1'b0, 1'b0, "load_1");
    step(1'b1, 32'h2,         1'b0, 1'b1, "async_assert");
    step(1'b0, 32'h2,         1'b0, 1'b0, "async_hold");

    step(1'b1, 32'h10,        1'b0, 1'b0, "latency_10");
    step(1'b1, 32'h20,        1'b0, 1'b0, "latency_20");

    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "max");
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "max_repeat");
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, "msb");
    step(1'b1, 32'h0000_0007, 1'b0, 1'b0, "align_7");

    step(1'b1, 32'h0000_0100, 1'b0, 1'b1, "midrun_reset");
    step(1'b0, 32'h0000_0100, 1'b0, 1'b0, "midrun_hold");
    step(1'b1, 32'h0000_0004, 1'b0, 1'b0, "midrun_release");

    for (int i = 0; i < 60; i++) begin
      rnd_rst   = ($urandom_range(0, 9) != 0);
      rnd_async = rnd_rst && ($urandom_range(0, 11) == 0);
      step(rnd_rst, pc_t'($urandom), 1'b0, rnd_async, "random");
    end

    done = 1'b1;
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_program_counter
